// File: rtl/key_scan.sv
// key_scan: 4x3 alarm-clock keypad scanner.
// Drives one column per clock and accumulates the row hits over a 3-clock frame.
// A frame resolves to one key code, or to 4'hF when no key or several keys are seen.
// New digit presses taken while shift is high are pushed into a 4-deep digit buffer.
// The '*' key is reported as time_button and the '#' key as alarm_button.
module key_scan (
    input  logic       clk,
    input  logic       reset,
    input  logic       shift,
    input  logic [3:0] rows,
    output logic [2:0] columns,
    output logic [3:0] key,
    output logic [3:0] key_buffer_0,
    output logic [3:0] key_buffer_1,
    output logic [3:0] key_buffer_2,
    output logic [3:0] key_buffer_3,
    output logic       time_button,
    output logic       alarm_button
);

    localparam logic [3:0] KEY_NONE  = 4'hF;
    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_POUND = 4'hB;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_state_t;

    col_state_t r_state;
    logic [2:0] r_columns;

    // Frame accumulator. The hit count saturates at 2, and 2 means the frame is invalid.
    logic [1:0] r_acc_cnt;
    logic [3:0] r_acc_code;

    logic [3:0] r_key;
    logic [3:0] r_prev;
    logic [3:0] r_buf [4];
    logic       r_time_btn;
    logic       r_alarm_btn;

    logic [2:0] w_row_cnt;
    logic [1:0] w_row_idx;
    logic [3:0] w_hit_code;
    logic [2:0] w_sum;
    logic [1:0] w_tot_cnt;
    logic [3:0] w_tot_code;
    logic [3:0] w_frame_res;
    logic       w_press;
    logic       w_push;

    // Keypad map: row r, column c -> key code.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        if (r != 2'd3) begin
            code = 4'(r) * 4'd3 + 4'(c) + 4'd1;
        end else begin
            case (c)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'h0;
                default: code = KEY_POUND;
            endcase
        end
        return code;
    endfunction

    // Count the row hits on this clock and encode the row index, which is only meaningful for a single hit.
    always_comb begin
        w_row_cnt = 3'(rows[0]) + 3'(rows[1]) + 3'(rows[2]) + 3'(rows[3]);
        w_row_idx = 2'd0;
        case (rows)
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
        w_hit_code = key_code(w_row_idx, 2'(r_state));
    end

    // Merge this clock's hits into the frame so far, and decide the press and push events.
    always_comb begin
        w_sum       = {1'b0, r_acc_cnt} + w_row_cnt;
        w_tot_cnt   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_tot_code  = (w_row_cnt == 3'd1) ? w_hit_code : r_acc_code;
        w_frame_res = (w_tot_cnt == 2'd1) ? w_tot_code : KEY_NONE;
        w_press     = (w_frame_res != KEY_NONE) && (w_frame_res != r_prev);
        w_push      = w_press && shift && (w_frame_res <= 4'd9);
    end

    // Column scan FSM. The one-hot column drive is registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= COL0;
            r_columns <= 3'b001;
        end else begin
            case (r_state)
                COL0: begin
                    r_state   <= COL1;
                    r_columns <= 3'b010;
                end
                COL1: begin
                    r_state   <= COL2;
                    r_columns <= 3'b100;
                end
                default: begin
                    r_state   <= COL0;
                    r_columns <= 3'b001;
                end
            endcase
        end
    end

    // Accumulate hits across the frame, and on the column-2 clock commit the result to key and the buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_cnt   <= 2'd0;
            r_acc_code  <= KEY_NONE;
            r_key       <= KEY_NONE;
            r_prev      <= KEY_NONE;
            r_time_btn  <= 1'b0;
            r_alarm_btn <= 1'b0;
        end else if (r_state == COL2) begin
            r_acc_cnt   <= 2'd0;
            r_acc_code  <= KEY_NONE;
            r_key       <= w_frame_res;
            r_prev      <= w_frame_res;
            r_time_btn  <= (w_frame_res == KEY_STAR);
            r_alarm_btn <= (w_frame_res == KEY_POUND);
        end else begin
            r_acc_cnt   <= w_tot_cnt;
            r_acc_code  <= w_tot_code;
        end
    end

    // Digit shift buffer. A new digit press with shift high pushes the digit in as the newest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= 4'h0;
        end else if ((r_state == COL2) && w_push) begin
            r_buf[3] <= r_buf[2];
            r_buf[2] <= r_buf[1];
            r_buf[1] <= r_buf[0];
            r_buf[0] <= w_frame_res;
        end
    end

    assign columns      = r_columns;
    assign key          = r_key;
    assign key_buffer_0 = r_buf[0];
    assign key_buffer_1 = r_buf[1];
    assign key_buffer_2 = r_buf[2];
    assign key_buffer_3 = r_buf[3];
    assign time_button  = r_time_btn;
    assign alarm_button = r_alarm_btn;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan.
// A keypad model drives the rows from the column the DUT is driving.
// Each frame's expected outputs are pushed to a scoreboard when the frame is driven,
// then popped and compared after the commit edge.
module tb_key_scan;

    logic       clk;
    logic       reset;
    logic       shift;
    logic [3:0] rows;
    logic [2:0] columns;
    logic [3:0] key;
    logic [3:0] key_buffer_0, key_buffer_1, key_buffer_2, key_buffer_3;
    logic       time_button, alarm_button;

    int checks   = 0;
    int failures = 0;

    // Up to two held keys (row, column); a column of -1 means the key is not held.
    int k1r = 0, k1c = -1, k2r = 0, k2c = -1;

    typedef struct {
        logic [3:0] key;
        logic [3:0] b [4];
        logic       tbtn;
        logic       abtn;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_prev;
    logic [3:0] m_buf [4];

    key_scan dut (
        .clk(clk), .reset(reset), .shift(shift), .rows(rows), .columns(columns),
        .key(key), .key_buffer_0(key_buffer_0), .key_buffer_1(key_buffer_1),
        .key_buffer_2(key_buffer_2), .key_buffer_3(key_buffer_3),
        .time_button(time_button), .alarm_button(alarm_button)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a held key closes its row only while its column is driven.
    always_comb begin
        rows = 4'b0000;
        if (k1c >= 0 && columns[k1c]) rows[k1r] = 1'b1;
        if (k2c >= 0 && columns[k2c]) rows[k2r] = 1'b1;
    end

    function automatic logic [3:0] code_of(input int r, input int c);
        case (r)
            0: return (c == 0) ? 4'h1 : (c == 1) ? 4'h2 : 4'h3;
            1: return (c == 0) ? 4'h4 : (c == 1) ? 4'h5 : 4'h6;
            2: return (c == 0) ? 4'h7 : (c == 1) ? 4'h8 : 4'h9;
            default: return (c == 0) ? 4'hA : (c == 1) ? 4'h0 : 4'hB;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".columns"}, {1'b0, columns}, 4'b0001);
        check({tag, ".key"}, key, 4'hF);
        check({tag, ".buf0"}, key_buffer_0, 4'h0);
        check({tag, ".buf1"}, key_buffer_1, 4'h0);
        check({tag, ".buf2"}, key_buffer_2, 4'h0);
        check({tag, ".buf3"}, key_buffer_3, 4'h0);
        check({tag, ".time"}, {3'b0, time_button}, 4'h0);
        check({tag, ".alarm"}, {3'b0, alarm_button}, 4'h0);
    endtask

    // Drive one frame with the given keys held, push its expectation, run 3 clocks, then pop and compare.
    task automatic frame(input string tag, input int r1, input int c1, input int r2, input int c2,
                         input logic sh);
        exp_t       e;
        int         n;
        logic [3:0] code;
        k1r = r1; k1c = c1; k2r = r2; k2c = c2; shift = sh;
        n    = ((c1 >= 0) ? 1 : 0) + ((c2 >= 0) ? 1 : 0);
        code = (n == 1) ? ((c1 >= 0) ? code_of(r1, c1) : code_of(r2, c2)) : 4'hF;
        if (code != 4'hF && code != m_prev && sh && code <= 4'd9) begin
            m_buf[3] = m_buf[2]; m_buf[2] = m_buf[1]; m_buf[1] = m_buf[0]; m_buf[0] = code;
        end
        m_prev = code;
        e.key = code; e.b = m_buf; e.tbtn = (code == 4'hA); e.abtn = (code == 4'hB);
        sb.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".key"},  key, e.key);
            check({tag, ".buf0"}, key_buffer_0, e.b[0]);
            check({tag, ".buf1"}, key_buffer_1, e.b[1]);
            check({tag, ".buf2"}, key_buffer_2, e.b[2]);
            check({tag, ".buf3"}, key_buffer_3, e.b[3]);
            check({tag, ".time"},  {3'b0, time_button}, {3'b0, e.tbtn});
            check({tag, ".alarm"}, {3'b0, alarm_button}, {3'b0, e.abtn});
        end
    endtask

    task automatic press(input string tag, input int r, input int c, input logic sh);
        frame(tag, r, c, 0, -1, sh);
    endtask

    task automatic idle(input string tag, input logic sh);
        frame(tag, 0, -1, 0, -1, sh);
    endtask

    initial begin
        m_prev = 4'hF;
        for (int i = 0; i < 4; i++) m_buf[i] = 4'h0;
        reset = 1'b0; shift = 1'b0;

        // Reset hold, then the column rotation after release.
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;
        @(posedge clk); #1; check("rot.010", {1'b0, columns}, 4'b0010);
        @(posedge clk); #1; check("rot.100", {1'b0, columns}, 4'b0100);
        @(posedge clk); #1; check("rot.001", {1'b0, columns}, 4'b0001);
        check("rot.key", key, 4'hF);

        // Single press of '4' without shift.
        press("p4_noshift", 1, 0, 1'b0);
        idle("idle0", 1'b0);

        // Digit entry of 8, 2, 1, then 5.
        press("d8", 2, 1, 1'b1); idle("g8", 1'b1);
        press("d2", 0, 1, 1'b1); idle("g2", 1'b1);
        press("d1", 0, 0, 1'b1); idle("g1", 1'b1);
        press("d5", 1, 1, 1'b1); idle("g5", 1'b1);

        // Hold '7' for 10 frames; only one push should occur.
        for (int i = 0; i < 10; i++) press("hold7", 2, 0, 1'b1);
        idle("g7", 1'b1);

        // The '*' and '#' buttons.
        press("star", 3, 0, 1'b1); press("star_hold", 3, 0, 1'b1); idle("star_rel", 1'b1);
        press("pound", 3, 2, 1'b1); idle("pound_rel", 1'b1);

        // A direct change from '9' to '3' with no empty frame between them.
        press("d9", 2, 2, 1'b1); press("d3_direct", 0, 2, 1'b1); idle("g3", 1'b1);

        // Invalid frames: two rows in one column, then hits in two columns.
        frame("inv_samecol", 0, 0, 1, 0, 1'b1);
        frame("inv_twocol", 0, 0, 0, 1, 1'b1);
        idle("ginv", 1'b1);

        // A new digit with shift low, then '0' pushed.
        press("d6_noshift", 1, 2, 1'b0); idle("g6", 1'b1);
        press("d0", 3, 1, 1'b1); idle("g0", 1'b1);

        // Asynchronous reset in the middle of a frame.
        k1r = 1; k1c = 1; shift = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_reset_vals("async_rst");
        k1c = -1;
        m_prev = 4'hF;
        for (int i = 0; i < 4; i++) m_buf[i] = 4'h0;
        #2 reset = 1'b1;
        press("d3_after_rst", 0, 2, 1'b1);
        idle("g_end", 1'b1);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_empty observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
